program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 20, instruction word width written to instruction memory.
REQ-002 Parameter ADDRESS_WIDTH, default 8, instruction memory address width.
REQ-003 Parameter MEM_SIZE, default 256, instruction memory depth in words.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 load_start  input  1  one-cycle request to begin a program download.
REQ-007 rx_data  input  8  incoming serial byte.
REQ-008 rx_valid  input  1  rx_data holds a valid byte.
REQ-009 rx_ready  output  1  loader can accept a byte this cycle.
REQ-010 imem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-011 imem_addr  output  ADDRESS_WIDTH  instruction memory write address.
REQ-012 imem_wdata  output  DATA_WIDTH  instruction word to write.
REQ-013 cpu_hold  output  1  1 = processor core held in reset; 0 = core may run.
REQ-014 done  output  1  download completed and verified.
REQ-015 error  output  1  download aborted (format or checksum failure).
REQ-016 word_count  output  ADDRESS_WIDTH+1  words written in current/last download.

Function
REQ-017 Byte transfer SHALL occur only in a cycle where rx_valid=1 and rx_ready=1; rx_data is ignored otherwise.
REQ-018 Frame format SHALL be: header byte H (word count N = H+1, range 1..256), then 3N data bytes, then one checksum byte C.
REQ-019 Each word SHALL be assembled little-endian: byte0 -> bits[7:0], byte1 -> bits[15:8], byte2[3:0] -> bits[19:16].
REQ-020 byte2[7:4] nonzero SHALL abort to ERROR without writing that word.
REQ-021 Checksum SHALL pass when (H + all data bytes + C) mod 256 == 0; otherwise abort to ERROR.
REQ-022 States: IDLE, HDR, B0, B1, B2, WRITE, CSUM, DONE, ERROR.
REQ-023 IDLE/DONE/ERROR + load_start=1 -> HDR next cycle; cpu_hold=1, done=0, error=0, word_count=0, imem_addr=0, running sum cleared.
REQ-024 load_start SHALL be ignored in HDR, B0, B1, B2, WRITE, CSUM.
REQ-025 HDR -> B0 on accepted byte; B0 -> B1 -> B2 on accepted bytes; B2 -> WRITE on accepted valid byte2.
REQ-026 WRITE SHALL last exactly one cycle: imem_we=1, imem_addr=current address, imem_wdata=assembled word; rx_ready=0.
REQ-027 After WRITE: word_count increments, imem_addr increments; if word_count reaches N -> CSUM, else -> B0.
REQ-028 imem_addr SHALL not wrap: N=256 final write at address 255, no further address used.
REQ-029 CSUM -> DONE on accepted byte with passing checksum, else -> ERROR.
REQ-030 rx_ready=1 only in HDR, B0, B1, B2, CSUM.
REQ-031 cpu_hold=0 only in DONE; 1 in every other state.
REQ-032 done=1 only in DONE; error=1 only in ERROR; both held until next load_start or reset.
REQ-033 imem_we=0 outside WRITE; imem_addr/imem_wdata hold last value outside WRITE.
REQ-034 Stalls (rx_valid=0) of any length SHALL leave state and counters unchanged.

Reset
REQ-035 rst=0 at a rising edge SHALL force IDLE regardless of state, including mid-WRITE.
REQ-036 Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, word_count=0.
REQ-037 A partially received frame SHALL be discarded by reset; no write strobe in the cycle after reset release.

Verification
REQ-038 Load 2 words: H=0x01, bytes 0x34,0x12,0x05, 0xCD,0xAB,0x0F, C=(256-sum) -> writes 0x51234 @0, 0xFABCD @1, done=1, cpu_hold=0, word_count=2.
REQ-039 Bad checksum on 1-word frame -> word written @0, then error=1, done=0, cpu_hold=1.
REQ-040 byte2=0x15 -> no imem_we for that word, error=1, state ERROR; subsequent load_start restarts cleanly.
REQ-041 H=0xFF with 768 data bytes, random rx_valid gaps -> 256 writes @0..255, word_count=256, addresses never wrap.
REQ-042 rst=0 after B1 of word 3 -> all outputs at reset values next cycle; new frame then loads from address 0.
REQ-043 load_start pulsed during B0 -> ignored; frame completes normally.

Source files
------------

// File: rtl/program_loader.sv
// Serial program loader: receives a framed byte stream, assembles 20-bit
// instruction words, writes them to instruction memory and verifies a checksum.
module program_loader #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0]    imem_wdata,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH:0]   word_count
);

    localparam int CW = ADDRESS_WIDTH + 1;

    typedef enum logic [3:0] {
        IDLE, HDR, B0, B1, B2, WRITE, CSUM, DONE, ERROR
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] n_words;
    logic [7:0]    byte0;
    logic [7:0]    byte1;
    logic [7:0]    sum;
    logic [7:0]    sum_add;
    logic          take;
    logic          last_word;
    logic          addr_room;
    logic          idle_like;

    assign rx_ready  = (state == HDR) || (state == B0) || (state == B1)
                    || (state == B2) || (state == CSUM);
    assign take      = rx_valid && rx_ready;
    assign sum_add   = sum + rx_data;
    assign last_word = (word_count + CW'(1)) == n_words;
    assign addr_room = {1'b0, imem_addr} < CW'(MEM_SIZE - 1);
    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);

    assign imem_we  = (state == WRITE);
    assign cpu_hold = (state != DONE);
    assign done     = (state == DONE);
    assign error    = (state == ERROR);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERROR: if (load_start) state_nxt = HDR;
            HDR:   if (take) state_nxt = B0;
            B0:    if (take) state_nxt = B1;
            B1:    if (take) state_nxt = B2;
            B2:    if (take) state_nxt = (rx_data[7:4] != 4'd0) ? ERROR : WRITE;
            WRITE: state_nxt = last_word ? CSUM : B0;
            CSUM:  if (take) state_nxt = (sum_add == 8'd0) ? DONE : ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            n_words    <= '0;
            byte0      <= '0;
            byte1      <= '0;
            sum        <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
        end else begin
            if (idle_like && load_start) begin
                word_count <= '0;
                imem_addr  <= '0;
                sum        <= '0;
            end
            if (take) sum <= sum_add;
            if (take && state == HDR) n_words <= CW'(rx_data) + CW'(1);
            if (take && state == B0)  byte0 <= rx_data;
            if (take && state == B1)  byte1 <= rx_data;
            if (take && state == B2 && rx_data[7:4] == 4'd0)
                imem_wdata <= DATA_WIDTH'({rx_data[3:0], byte1, byte0});
            // Address saturates on the final word so it never wraps past the top.
            if (state == WRITE) begin
                word_count <= word_count + CW'(1);
                if (!last_word && addr_room)
                    imem_addr <= imem_addr + ADDRESS_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: fixed frame table, corner sequences and
// randomized frames compared against a frame-level reference model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [19:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    program_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0]  frm[$];
    logic [19:0] exp_w[$];
    int          got_a[$];
    int          got_d[$];
    bit          exp_done;
    bit          exp_err;
    int          n_send;

    typedef struct {
        int          nb;
        logic [63:0] by;
        int          nw;
        logic [39:0] ws;
        bit          dn;
        bit          er;
    } vec_t;

    vec_t vecs[5];

    always @(negedge clk) begin
        if (imem_we) begin
            got_a.push_back(int'(imem_addr));
            got_d.push_back(int'(imem_wdata));
        end
    end

    task automatic check(input string nm, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", 0, 1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 rx_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rx_valid   = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Reference: derive writes and outcome from the frame's byte rules.
    task automatic build_model();
        int n, s, idx, b0, b1, b2;
        bit bad;
        exp_w.delete();
        n   = int'(frm[0]) + 1;
        s   = int'(frm[0]);
        idx = 1;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            b0 = int'(frm[idx]);
            b1 = int'(frm[idx + 1]);
            b2 = int'(frm[idx + 2]);
            idx += 3;
            s += b0 + b1 + b2;
            if (b2 > 15) begin
                bad = 1;
                break;
            end
            exp_w.push_back(20'(b2 * 65536 + b1 * 256 + b0));
        end
        if (bad) begin
            exp_err  = 1;
            exp_done = 0;
            n_send   = idx;
        end else begin
            n_send   = idx + 1;
            exp_done = ((s + int'(frm[idx])) % 256) == 0;
            exp_err  = !exp_done;
        end
    endtask

    task automatic load_vec(input int v);
        frm.delete();
        exp_w.delete();
        for (int k = 0; k < vecs[v].nb; k++) frm.push_back(vecs[v].by[8*k +: 8]);
        for (int k = 0; k < vecs[v].nw; k++) exp_w.push_back(vecs[v].ws[20*k +: 20]);
        n_send   = vecs[v].nb;
        exp_done = vecs[v].dn;
        exp_err  = vecs[v].er;
    endtask

    task automatic run_frame(input int maxgap, input bit ls_mid);
        int nmin;
        got_a.delete();
        got_d.delete();
        pulse_start();
        check("hdr_ready", rx_ready, 1);
        check("hdr_word_count", word_count, 0);
        check("hdr_hold", cpu_hold, 1);
        check("hdr_done", done, 0);
        check("hdr_error", error, 0);
        for (int k = 0; k < n_send; k++) begin
            send_byte(frm[k], $urandom_range(0, maxgap));
            if (ls_mid && k == 0) pulse_start();
        end
        repeat (4) @(negedge clk);
        check("write_count", got_a.size(), exp_w.size());
        nmin = (got_a.size() < exp_w.size()) ? got_a.size() : exp_w.size();
        for (int i = 0; i < nmin; i++) begin
            check("write_addr", got_a[i], i);
            check("write_data", got_d[i], exp_w[i]);
        end
        check("done", done, exp_done);
        check("error", error, exp_err);
        check("cpu_hold", cpu_hold, !exp_done);
        check("word_count", word_count, exp_w.size());
        check("end_ready", rx_ready, 0);
        check("end_we", imem_we, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, rx_ready, 0);
        check({tag, "_we"}, imem_we, 0);
        check({tag, "_addr"}, imem_addr, 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_hold"}, cpu_hold, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_wc"}, word_count, 0);
    endtask

    initial begin
        vecs[0] = '{8, 64'h2D_0F_AB_CD_05_12_34_01, 2, 40'hFABCD_51234, 1'b1, 1'b0};
        vecs[1] = '{5, 64'h00_03_22_11_00, 1, 40'h00000_32211, 1'b0, 1'b1};
        vecs[2] = '{4, 64'h15_22_11_00, 0, 40'h0, 1'b0, 1'b1};
        vecs[3] = '{5, 64'hF3_0F_FF_FF_00, 1, 40'h00000_FFFFF, 1'b1, 1'b0};
        vecs[4] = '{7, 64'h80_05_04_03_02_01_01, 1, 40'h00000_30201, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);
        check("idle_we", imem_we, 0);

        for (int v = 0; v < 5; v++) begin
            load_vec(v);
            run_frame(v % 3, 1'b0);
        end

        // load_start during B0 must be ignored
        load_vec(0);
        run_frame(1, 1'b1);

        // reset after byte1 of the third word of a 4-word frame
        frm = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        pulse_start();
        foreach (frm[k]) send_byte(frm[k], 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midframe_rst");
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_we", imem_we, 0);
        check("post_rst_ready", rx_ready, 0);
        load_vec(0);
        run_frame(0, 1'b0);

        // reset landing in the WRITE cycle
        frm = '{8'h00, 8'h11, 8'h22, 8'h03};
        pulse_start();
        foreach (frm[k]) send_byte(frm[k], 0);
        @(negedge clk);
        check("write_strobe", imem_we, 1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("write_rst");
        rst = 1'b1;
        @(negedge clk);

        // randomized short frames
        for (int f = 0; f < 20; f++) begin
            int nw, s;
            logic [7:0] b;
            nw = $urandom_range(1, 6);
            frm.delete();
            frm.push_back(8'(nw - 1));
            s = nw - 1;
            for (int k = 0; k < 3 * nw; k++) begin
                b = 8'($urandom);
                if (k % 3 == 2 && $urandom_range(0, 9) != 0) b = b & 8'h0F;
                frm.push_back(b);
                s += int'(b);
            end
            b = 8'((256 - (s % 256)) % 256);
            if ($urandom_range(0, 4) == 0) b = b + 8'($urandom_range(1, 255));
            frm.push_back(b);
            build_model();
            run_frame(3, 1'($urandom_range(0, 1)));
        end

        // full-depth frame with random stalls
        begin
            int s;
            logic [7:0] b;
            frm.delete();
            frm.push_back(8'hFF);
            s = 255;
            for (int k = 0; k < 768; k++) begin
                b = 8'($urandom);
                if (k % 3 == 2) b = b & 8'h0F;
                frm.push_back(b);
                s += int'(b);
            end
            frm.push_back(8'((256 - (s % 256)) % 256));
            build_model();
            run_frame(2, 1'b0);
            check("full_imem_addr", imem_addr, 255);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
